fetch_align_buffer: RTL

Halfword-granular instruction buffer between the instruction memory port and Decode. It issues 64-bit aligned fetch requests and queues the returned halfwords. It presents Decode with a 64-bit window starting at the current PC, at any halfword alignment. Decode reports how many halfwords it consumed (1 per 16-bit instruction, 2 per 32-bit instruction), so mixed 16/32-bit streams are realigned without refetching.

---
 rtl/fetch_align_buffer_if.sv | 47 ++++
 rtl/fetch_align_buffer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_align_buffer_if
//  Description : Bundles the redirect, memory-fetch and Decode-window signals
//                of the fetch align buffer. The master modport is the buffer
//                side; the slave modport is the surrounding core/memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_align_buffer_if #(
  parameter int DEPTH_HW = 16
);
  localparam int CW = $clog2(DEPTH_HW) + 1;

  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic [63:0]   resp_data;
  logic          out_valid;
  logic [63:0]   out_instr;
  logic [31:0]   out_pc;
  logic [2:0]    consume_hw;
  logic [CW-1:0] count_hw;

  modport master (
    input  redirect_valid, redirect_pc,
    output req_valid, req_addr,
    input  req_ready,
    input  resp_valid, resp_data,
    output out_valid, out_instr, out_pc,
    input  consume_hw,
    output count_hw
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  req_valid, req_addr,
    output req_ready,
    output resp_valid, resp_data,
    input  out_valid, out_instr, out_pc,
    output consume_hw,
    input  count_hw
  );
endinterface
`default_nettype wire

// File: rtl/fetch_align_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_align_buffer
//  Description : Halfword-granular instruction queue between the instruction
//                memory port and Decode. Issues 8-byte aligned fetches (one
//                outstanding at most), queues the returned halfwords, and
//                presents a 4-halfword window at the current PC at any
//                halfword alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_align_buffer #(
  parameter int          DEPTH_HW = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  fetch_align_buffer_if.master  bus
);

  localparam int          PW         = $clog2(DEPTH_HW);
  localparam int          CW         = PW + 1;
  localparam logic [63:0] C_NOP_PAIR = 64'h00000013_00000013;

  // Queue storage and bookkeeping
  logic [15:0]   r_q [DEPTH_HW];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_out_pc;
  logic [1:0]    r_drop_hw;
  logic          r_outstanding;
  logic          r_kill;

  logic [CW-1:0] w_free;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_resp_take;
  logic          w_push;
  logic [2:0]    w_push_n;
  logic          w_out_valid;
  logic          w_pop_legal;
  logic [2:0]    w_pop_n;
  logic [63:0]   w_window;

  // Request / push / pop qualification from registered state and inputs
  always_comb begin
    w_free      = CW'(DEPTH_HW) - r_count;
    // Reset keeps the request quiet even before state has been initialised.
    w_req_valid = !rst && !r_outstanding && (w_free >= CW'(4)) && !bus.redirect_valid;
    w_req_fire  = w_req_valid && bus.req_ready;
    w_resp_take = bus.resp_valid && r_outstanding;
    // Killed (stale) data and data arriving alongside a redirect are dropped.
    w_push      = w_resp_take && !r_kill && !bus.redirect_valid;
    w_push_n    = w_push ? (3'd4 - {1'b0, r_drop_hw}) : 3'd0;
    w_out_valid = (r_count >= CW'(4));
    // Illegal consume values pop nothing rather than corrupting the queue.
    w_pop_legal = w_out_valid && (bus.consume_hw != 3'd0) && (bus.consume_hw <= 3'd4);
    w_pop_n     = (w_pop_legal && !bus.redirect_valid) ? bus.consume_hw : 3'd0;
  end

  // Gather the four halfwords at the head; indices wrap so the window may straddle
  always_comb begin
    w_window = '0;
    for (int k = 0; k < 4; k++) begin
      w_window[16*k +: 16] = r_q[r_rd_ptr + PW'(k)];
    end
  end

  assign bus.req_valid = w_req_valid;
  assign bus.req_addr  = r_fetch_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_valid ? w_window : C_NOP_PAIR;
  assign bus.out_pc    = r_out_pc;
  assign bus.count_hw  = r_count;

  // Queue write: halfwords drop_hw..3 land contiguously starting at wr_ptr
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int k = 0; k < 4; k++) begin
        if (2'(k) >= r_drop_hw) begin
          r_q[r_wr_ptr + PW'(k) - PW'(r_drop_hw)] <= bus.resp_data[16*k +: 16];
        end
      end
    end
  end

  // Pointer, PC and fetch-protocol state; redirect overrides everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_fetch_pc    <= {RESET_PC[31:3], 3'b000};
      r_drop_hw     <= RESET_PC[2:1];
      r_out_pc      <= {RESET_PC[31:1], 1'b0};
      r_outstanding <= 1'b0;
      r_kill        <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= {bus.redirect_pc[31:3], 3'b000};
      r_drop_hw  <= bus.redirect_pc[2:1];
      r_out_pc   <= {bus.redirect_pc[31:1], 1'b0};
      if (r_outstanding) begin
        if (bus.resp_valid) begin
          // The in-flight response completes now and is simply discarded.
          r_outstanding <= 1'b0;
          r_kill        <= 1'b0;
        end else begin
          // Response still in flight: mark it stale (sticky across redirects).
          r_kill <= 1'b1;
        end
      end
    end else begin
      if (w_req_fire) begin
        r_outstanding <= 1'b1;
        r_fetch_pc    <= r_fetch_pc + 32'd8;
      end
      if (w_resp_take) begin
        r_outstanding <= 1'b0;
        if (r_kill) begin
          r_kill <= 1'b0;
        end else begin
          r_drop_hw <= 2'd0;
        end
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
      r_count  <= r_count + CW'(w_push_n) - CW'(w_pop_n);
      r_out_pc <= r_out_pc + {28'd0, w_pop_n, 1'b0};
    end
  end

  // Memory must never return data without a request in flight
  a_resp_needs_request : assert property (@(posedge clk) disable iff (rst)
    !(bus.resp_valid && !r_outstanding));

  // Decode may only consume 1..4 halfwords from a valid window
  a_consume_legal : assert property (@(posedge clk) disable iff (rst)
    (bus.consume_hw != 3'd0) |-> (w_out_valid && (bus.consume_hw <= 3'd4)));

endmodule
`default_nettype wire
